// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: writeback source select, load type, PC+8 offset.
// Load extension is compiled in only when WB_LOAD_EXT_EN is defined.
package wb_pkg;

    typedef enum logic [1:0] {
        WD_ALU = 2'd0,
        WD_MEM = 2'd1,
        WD_PC8 = 2'd2,
        WD_MD  = 2'd3
    } wd_sel_e;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LB  = 3'd1,
        LD_LBU = 3'd2,
        LD_LH  = 3'd3,
        LD_LHU = 3'd4
    } ld_type_e;

    localparam logic [31:0] PC8_OFFSET = 32'd8;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        return {{24{sgn & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        return {{16{sgn & h[15]}}, h};
    endfunction

endpackage

// File: rtl/load_ext.sv
// Combinational load data extender: picks the addressed byte/halfword and sign- or zero-extends it.
// Load types outside the defined set behave as a full-word load.
module load_ext
    import wb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_type,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[7:0];
        case (addr_lo)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    // Halfword loads are aligned by construction, so only addr_lo[1] matters.
    assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (ld_type)
            LD_LB:   data = ext8(byte_sel, 1'b1);
            LD_LBU:  data = ext8(byte_sel, 1'b0);
            LD_LH:   data = ext16(half_sel, 1'b1);
            LD_LHU:  data = ext16(half_sel, 1'b0);
            default: data = word;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// M->W pipeline register and writeback data mux, with a retired-instruction counter.
// Define WB_LOAD_EXT_EN to register load type/offset and enable sub-word load extension.
module wb_stage
    import wb_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] m_pc,
    input  logic [4:0]  m_a3,
    input  logic [1:0]  m_wd_sel,
    input  logic [31:0] m_alu,
    input  logic [31:0] m_md,
    input  logic [31:0] m_mem_rd,
    input  logic [1:0]  m_addr_lo,
    input  logic [2:0]  m_ld_type,
    output logic [4:0]  w_a3,
    output logic [31:0] w_wd,
    output logic [31:0] w_pc,
    output logic        w_valid,
    output logic [31:0] retire_cnt
);

    // Load protocol: flush wins over en and loads a bubble; otherwise en=1 advances
    // the register by one instruction and en=0 holds it. The instruction leaving W
    // (advance or flush while w_valid) is the one counted as retired.
    wd_sel_e     wd_sel_q;
    logic [31:0] alu_q;
    logic [31:0] md_q;
    logic [31:0] mem_rd_q;
    logic [31:0] mem_data;
    logic        advance;

    assign advance = en | flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_a3     <= '0;
            w_pc     <= RESET_PC;
            w_valid  <= 1'b0;
            wd_sel_q <= WD_ALU;
            alu_q    <= '0;
            md_q     <= '0;
            mem_rd_q <= '0;
        end else if (flush) begin
            w_a3     <= '0;
            w_pc     <= RESET_PC;
            w_valid  <= 1'b0;
            wd_sel_q <= WD_ALU;
            alu_q    <= '0;
            md_q     <= '0;
            mem_rd_q <= '0;
        end else if (en) begin
            w_a3     <= m_a3;
            w_pc     <= m_pc;
            w_valid  <= 1'b1;
            wd_sel_q <= wd_sel_e'(m_wd_sel);
            alu_q    <= m_alu;
            md_q     <= m_md;
            mem_rd_q <= m_mem_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (w_valid && advance) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [1:0] addr_lo_q;
    logic [2:0] ld_type_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_lo_q <= '0;
            ld_type_q <= '0;
        end else if (flush) begin
            addr_lo_q <= '0;
            ld_type_q <= '0;
        end else if (en) begin
            addr_lo_q <= m_addr_lo;
            ld_type_q <= m_ld_type;
        end
    end

    load_ext u_load_ext (
        .word    (mem_rd_q),
        .addr_lo (addr_lo_q),
        .ld_type (ld_type_q),
        .data    (mem_data)
    );
`else
    // Without extension the load-shape inputs are intentionally ignored.
    logic unused_ld_shape;
    assign unused_ld_shape = ^{m_addr_lo, m_ld_type};
    assign mem_data = mem_rd_q;
`endif

    always_comb begin
        w_wd = '0;
        case (wd_sel_q)
            WD_ALU:  w_wd = alu_q;
            WD_MEM:  w_wd = mem_data;
            WD_PC8:  w_wd = w_pc + PC8_OFFSET;
            WD_MD:   w_wd = md_q;
            default: w_wd = alu_q;
        endcase
    end

endmodule
